snake_game_sequencer: RTL

Top-level game controller for the snake datapath. It sequences the game loop IDLE -> fruit spawn -> tick wait -> snake step -> result check -> game over. It derives game_tik from the VGA frame_tik and owns direction, score, length and speed. It drives the snake-body and fruit-generator datapaths through req/done handshakes and sits beside the VGA timing block inside the game wrapper.

---
 rtl/snake_pkg.sv | 52 +++++
 rtl/tik_divider.sv | 34 +++
 rtl/snake_game_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared state, direction and turn encodings for the snake game
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPAWN     = 3'd1,
        ST_WAIT_TIK  = 3'd2,
        ST_STEP      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TURN_NONE = 2'd0,
        TURN_CW   = 2'd1,
        TURN_CCW  = 2'd2
    } turn_t;

    // One-hot {up,down,left,right}
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    function automatic logic [3:0] rotate_cw(input logic [3:0] d);
        case (d)
            DIR_RIGHT: rotate_cw = DIR_DOWN;
            DIR_DOWN:  rotate_cw = DIR_LEFT;
            DIR_LEFT:  rotate_cw = DIR_UP;
            DIR_UP:    rotate_cw = DIR_RIGHT;
            default:   rotate_cw = DIR_RIGHT;
        endcase
    endfunction

    function automatic logic [3:0] rotate_ccw(input logic [3:0] d);
        case (d)
            DIR_RIGHT: rotate_ccw = DIR_UP;
            DIR_UP:    rotate_ccw = DIR_LEFT;
            DIR_LEFT:  rotate_ccw = DIR_DOWN;
            DIR_DOWN:  rotate_ccw = DIR_RIGHT;
            default:   rotate_ccw = DIR_RIGHT;
        endcase
    endfunction

    function automatic logic [3:0] apply_turn(input logic [3:0] d, input turn_t t);
        case (t)
            TURN_CW:  apply_turn = rotate_cw(d);
            TURN_CCW: apply_turn = rotate_ccw(d);
            default:  apply_turn = d;
        endcase
    endfunction

endpackage

// File: rtl/tik_divider.sv
// rtl/tik_divider.sv - counts frame_tik pulses and fires once per loadable period
module tik_divider (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic       i_frame_tik,
    input  logic [5:0] i_period,
    output logic       o_fire,
    output logic       o_game_tik
);

    logic [5:0] r_frame_cnt;
    logic       r_game_tik;

    // o_fire is combinational so the sequencer can change state on the same edge
    assign o_fire     = i_enable && i_frame_tik && (r_frame_cnt == i_period - 6'd1);
    assign o_game_tik = r_game_tik;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= 6'd0;
            r_game_tik  <= 1'b0;
        end else begin
            r_game_tik <= o_fire;
            if (i_clear || o_fire) begin
                r_frame_cnt <= 6'd0;
            end else if (i_enable && i_frame_tik) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/snake_game_sequencer.sv
// rtl/snake_game_sequencer.sv - snake game loop controller: tick timing, turns, score, speed and datapath handshakes
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int FRAMES_PER_TIK_INIT = 30,
    parameter int FRAMES_PER_TIK_MIN  = 6,
    parameter int SPEEDUP_STEP        = 2,
    parameter int SCORE_PER_SPEEDUP   = 4,
    parameter int INIT_LENGTH         = 3,
    parameter int MAX_LENGTH          = 15
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       frame_tik,
    input  logic       right_pulse,
    input  logic       left_pulse,
    input  logic       step_done,
    input  logic       collision_detected,
    input  logic       fruit_eaten,
    input  logic       spawn_done,
    output logic [2:0] current_state,
    output logic       game_tik,
    output logic       step_req,
    output logic       grow,
    output logic       spawn_req,
    output logic [3:0] dir,
    output logic [7:0] score,
    output logic [3:0] snake_length,
    output logic       game_over
);

    localparam logic [5:0] PERIOD_INIT  = 6'(FRAMES_PER_TIK_INIT);
    localparam logic [5:0] PERIOD_MIN   = 6'(FRAMES_PER_TIK_MIN);
    localparam logic [5:0] PERIOD_STEP  = 6'(SPEEDUP_STEP);
    localparam logic [6:0] PERIOD_CLAMP = 7'(FRAMES_PER_TIK_MIN + SPEEDUP_STEP);
    localparam logic [3:0] LEN_INIT     = 4'(INIT_LENGTH);
    localparam logic [3:0] LEN_MAX      = 4'(MAX_LENGTH);
    localparam logic [7:0] SCORE_DIV    = 8'(SCORE_PER_SPEEDUP);

    state_t     r_state;
    state_t     w_next_state;
    turn_t      r_pending;
    turn_t      w_turn;
    logic [3:0] r_dir;
    logic [3:0] r_length;
    logic [7:0] r_score;
    logic [5:0] r_period;
    logic       r_grow;
    logic       r_step_req;
    logic       r_spawn_req;
    logic       r_game_over;
    logic       w_button;
    logic       w_step_ack;
    logic       w_spawn_ack;
    logic       w_restart;
    logic       w_fruit;
    logic       w_fire;
    logic       w_game_tik;
    logic       w_speedup;
    logic [7:0] w_score_inc;

    assign w_button    = right_pulse | left_pulse;
    assign w_step_ack  = r_step_req & step_done;
    assign w_spawn_ack = r_spawn_req & spawn_done;
    assign w_restart   = (r_state == ST_GAME_OVER) & w_button;
    assign w_fruit     = w_step_ack & ~collision_detected & fruit_eaten;
    assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_speedup   = (w_score_inc != 8'd0) && ((w_score_inc % SCORE_DIV) == 8'd0);

    // Simultaneous right+left cancels; turns outside the play states are dropped
    always_comb begin
        w_turn = TURN_NONE;
        if (r_state == ST_SPAWN || r_state == ST_WAIT_TIK || r_state == ST_STEP) begin
            if (right_pulse && !left_pulse) begin
                w_turn = TURN_CW;
            end else if (left_pulse && !right_pulse) begin
                w_turn = TURN_CCW;
            end
        end
    end

    tik_divider u_tik_divider (
        .i_clk       (clock_25),
        .i_rst_n     (reset),
        .i_enable    (r_state == ST_WAIT_TIK),
        .i_clear     (w_spawn_ack | w_restart),
        .i_frame_tik (frame_tik),
        .i_period    (r_period),
        .o_fire      (w_fire),
        .o_game_tik  (w_game_tik)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_button) w_next_state = ST_SPAWN;
            ST_SPAWN:     if (w_spawn_ack) w_next_state = ST_WAIT_TIK;
            ST_WAIT_TIK:  if (w_fire) w_next_state = ST_STEP;
            ST_STEP: begin
                if (w_step_ack) begin
                    if (collision_detected) begin
                        w_next_state = ST_GAME_OVER;
                    end else if (fruit_eaten) begin
                        w_next_state = ST_SPAWN;
                    end else begin
                        w_next_state = ST_WAIT_TIK;
                    end
                end
            end
            ST_GAME_OVER: if (w_button) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_dir       <= DIR_RIGHT;
            r_score     <= 8'd0;
            r_length    <= LEN_INIT;
            r_period    <= PERIOD_INIT;
            r_pending   <= TURN_NONE;
            r_grow      <= 1'b0;
            r_step_req  <= 1'b0;
            r_spawn_req <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            // Requests rise one cycle after state entry and drop on the edge that samples done
            r_step_req  <= (r_state == ST_STEP) && !w_step_ack;
            r_spawn_req <= (r_state == ST_SPAWN) && !w_spawn_ack;
            r_game_over <= (w_next_state == ST_GAME_OVER);
            if (w_restart) begin
                r_dir     <= DIR_RIGHT;
                r_score   <= 8'd0;
                r_length  <= LEN_INIT;
                r_period  <= PERIOD_INIT;
                r_pending <= TURN_NONE;
                r_grow    <= 1'b0;
            end else begin
                if (w_fire) begin
                    r_dir     <= apply_turn(r_dir, r_pending);
                    r_pending <= w_turn;
                end else if (w_turn != TURN_NONE) begin
                    r_pending <= w_turn;
                end
                if (w_step_ack) begin
                    r_grow <= w_fruit;
                end
                if (w_fruit) begin
                    r_score  <= w_score_inc;
                    r_length <= (r_length >= LEN_MAX) ? LEN_MAX : r_length + 4'd1;
                    if (w_speedup) begin
                        r_period <= ({1'b0, r_period} <= PERIOD_CLAMP) ? PERIOD_MIN
                                                                      : r_period - PERIOD_STEP;
                    end
                end
            end
        end
    end

    assign current_state = r_state;
    assign game_tik      = w_game_tik;
    assign step_req      = r_step_req;
    assign grow          = r_grow;
    assign spawn_req     = r_spawn_req;
    assign dir           = r_dir;
    assign score         = r_score;
    assign snake_length  = r_length;
    assign game_over     = r_game_over;

endmodule
